// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: redirect/stall inputs, byte-wide arbiter port and the if_id-facing instruction outputs.
// Master is the fetch stage; slave is the environment (ctrl, decode, arbiter, if_id).
interface if_fetch_if;
    logic        stall;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    modport master (
        input  stall, jump_flag, jump_addr, mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, if_pc, if_inst, if_valid
    );

    modport slave (
        output stall, jump_flag, jump_addr, mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, if_pc, if_inst, if_valid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: builds each 32-bit word from four little-endian byte reads, 8 cycles best case.
// Holds the word while stall is high; a redirect overrides everything and flushes any in-flight byte.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    if_fetch_if.master bus
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DONE, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] hold_pc_q, hold_inst_q;
    logic        valid;
    logic        unused_jump_lsb;

    assign unused_jump_lsb = ^bus.jump_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_REQ: begin
                if (bus.mem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                if (!bus.stall) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                if (bus.mem_rvalid) begin
                    cnt_d   = 2'd0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A granted or still-outstanding byte must be drained in FLUSH before refetching.
        if (bus.jump_flag) begin
            pc_d  = {bus.jump_addr[31:2], 2'b00};
            cnt_d = 2'd0;
            buf_d = buf_q;
            case (state_q)
                S_REQ:   state_d = bus.mem_gnt    ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = bus.mem_rvalid ? S_REQ   : S_FLUSH;
                S_FLUSH: state_d = bus.mem_rvalid ? S_REQ   : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end
    end

    assign valid = !rst && (state_q == S_DONE) && !bus.jump_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_pc_q   <= 32'd0;
            hold_inst_q <= 32'd0;
        end else if (valid) begin
            hold_pc_q   <= pc_q;
            hold_inst_q <= buf_q;
        end
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_addr = 32'd0;
        bus.if_valid = 1'b0;
        bus.if_pc    = 32'd0;
        bus.if_inst  = 32'd0;
        if (!rst) begin
            bus.mem_req  = (state_q == S_REQ);
            bus.mem_addr = pc_q + {30'd0, cnt_q};
            bus.if_valid = valid;
            bus.if_pc    = valid ? pc_q  : hold_pc_q;
            bus.if_inst  = valid ? buf_q : hold_inst_q;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table, a hand-written redirect sequence, then randomized traffic vs a word-level model.
module tb_if_fetch;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    if_fetch_if bus();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, jump;
        logic [31:0] jaddr;
        logic        gnt, rv;
        logic [7:0]  rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid, chk_out;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic j, input logic [31:0] ja,
                       input logic g, input logic v, input logic [7:0] d,
                       input logic eq, input logic [31:0] ea, input logic ev, input logic co,
                       input logic [31:0] ep, input logic [31:0] ei);
        vec_t t;
        t.rst = r; t.stall = s; t.jump = j; t.jaddr = ja; t.gnt = g; t.rv = v; t.rd = d;
        t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.chk_out = co; t.e_pc = ep; t.e_inst = ei;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] ja,
                         input logic g, input logic v, input logic [7:0] d);
        rst = r; bus.stall = s; bus.jump_flag = j; bus.jump_addr = ja;
        bus.mem_gnt = g; bus.mem_rvalid = v; bus.mem_rdata = d;
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return (a[7:0] ^ a[31:24]) + a[15:8] * 8'd3 + a[23:16] * 8'd7 + 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic fetch_rows(input logic [31:0] base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            add(0, 0, 0, 0, 1, 0, 8'h00, 1, base + k, 0, 0, 0, 0);
            add(0, 0, 0, 0, 0, 1, w[8*k +: 8], 0, 0, 0, 0, 0, 0);
        end
    endtask

    logic [31:0] exp_pc, paddr, ja;
    logic        pend, st, jf, gn, rv;
    logic [7:0]  rd;
    int          left, acc;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        // Directed table: first fetch, stall hold, gnt backpressure, redirects, wrap, reset mid-WAIT.
        add(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0);
        fetch_rows(32'h0, 32'h0010_0513);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0010_0513);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0010_0513);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 1, 32'h0, 32'h0010_0513);
        fetch_rows(32'h4, 32'h4433_2211);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h4, 32'h4433_2211);
        add(0, 0, 0, 0, 1, 0, 0, 1, 32'h8, 0, 0, 0, 0);
        add(0, 0, 1, 32'h0000_1003, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'hEE, 0, 0, 0, 1, 32'h4, 32'h4433_2211);
        fetch_rows(32'h1000, 32'hDDCC_BBAA);
        add(0, 1, 1, 32'h0000_2008, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 1, 32'h2008, 0, 0, 0, 0);
        fetch_rows(32'hFFFF_FFFC, 32'h0403_0201);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0403_0201);
        add(0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1, 32'h0, 32'h0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].stall, vq[i].jump, vq[i].jaddr, vq[i].gnt, vq[i].rv, vq[i].rd);
            @(negedge clk);
            chk($sformatf("row%0d_req", i), {31'd0, bus.mem_req}, {31'd0, vq[i].e_req});
            if (vq[i].e_req) chk($sformatf("row%0d_addr", i), bus.mem_addr, vq[i].e_addr);
            chk($sformatf("row%0d_valid", i), {31'd0, bus.if_valid}, {31'd0, vq[i].e_valid});
            if (vq[i].e_valid || vq[i].chk_out) begin
                chk($sformatf("row%0d_pc", i), bus.if_pc, vq[i].e_pc);
                chk($sformatf("row%0d_inst", i), bus.if_inst, vq[i].e_inst);
            end
            @(posedge clk); #1;
        end

        // Redirect in REQ with grant, then a second redirect while flushing keeps the newer target.
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h0000_0300, 1, 0, 0);
        @(negedge clk);
        chk("seq_req_addr", bus.mem_addr, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h0000_0405, 0, 0, 0);
        @(negedge clk);
        chk("seq_flush_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1, 8'h77);
        @(negedge clk);
        chk("seq_flush_drain_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seq_refetch_req", {31'd0, bus.mem_req}, 32'd1);
        chk("seq_refetch_addr", bus.mem_addr, 32'h404);
        @(posedge clk); #1;

        // Randomized traffic against a word-level model of the fetched instruction stream.
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        exp_pc = 32'h0; pend = 1'b0; left = 0; acc = 0; paddr = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            st = ($urandom_range(0, 9) < 3);
            jf = ($urandom_range(0, 99) < 2);
            ja = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                             : ($urandom & 32'h0000_FFFF);
            gn = ($urandom_range(0, 9) < 6);
            rv = pend && (left == 0);
            rd = rv ? mem_byte(paddr) : 8'($urandom);
            drive(0, st, jf, ja, gn, rv, rd);
            @(negedge clk);
            if (jf) begin
                chk("rand_jump_hides_valid", {31'd0, bus.if_valid}, 32'd0);
                exp_pc = {ja[31:2], 2'b00};
            end else if (bus.if_valid && !st) begin
                chk("rand_pc", bus.if_pc, exp_pc);
                chk("rand_inst", bus.if_inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                acc++;
            end
            if (rv) pend = 1'b0;
            else if (pend) left--;
            if (bus.mem_req && gn) begin
                chk("rand_one_outstanding", {31'd0, pend}, 32'd0);
                pend  = 1'b1;
                paddr = bus.mem_addr;
                left  = $urandom_range(0, 2);
            end
            @(posedge clk); #1;
        end
        chk("rand_progress", {31'd0, acc >= 30}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of if_id, which feeds the decode stage.
- Owns the PC and assembles each 32-bit instruction from four byte reads through the memory arbiter's byte-wide port.
- Presents {pc, inst, valid} to if_id, holds the instruction under ctrl stall, and redirects on jump_flag/jump_addr from decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  from ctrl; 1 = if_id cannot accept this cycle.
- jump_flag  in  1  from decode; redirect request.
- jump_addr  in  32  from decode; redirect target.
- mem_req  out  1  byte read request to arbiter.
- mem_addr  out  32  byte address of the request.
- mem_gnt  in  1  arbiter accepted the request this cycle.
- mem_rvalid  in  1  read byte returned this cycle.
- mem_rdata  in  8  returned byte.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  assembled instruction.
- if_valid  out  1  if_pc/if_inst are valid this cycle.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc<=RESET_PC, cnt<=0, state<=REQ.
  - Outputs while rst=1: mem_req=0, mem_addr=0, if_pc=0, if_inst=0, if_valid=0.
- State machine: states REQ, WAIT, DONE, FLUSH. One outstanding byte request at most.
  - REQ: mem_req=1, mem_addr=pc+cnt. mem_gnt=1 -> WAIT; otherwise stay in REQ with mem_req held.
  - WAIT: mem_req=0. On mem_rvalid, inst_buf[8*cnt+7:8*cnt]<=mem_rdata (little-endian). If cnt==3 -> DONE, cnt<=0; else cnt<=cnt+1 -> REQ.
  - DONE: if_valid=1, if_pc=pc, if_inst=inst_buf.
    - stall=0: pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), -> REQ.
    - stall=1: hold all state, if_valid stays 1.
  - FLUSH: mem_req=0; waits for one mem_rvalid, byte discarded, -> REQ with cnt=0.
- mem_rvalid outside WAIT/FLUSH is ignored. mem_gnt outside REQ is ignored.
- if_pc/if_inst hold their last values when if_valid=0; after reset they read 0.
- Redirect (jump_flag=1) has priority over every other event in the cycle:
  - pc<={jump_addr[31:2],2'b00}; cnt<=0.
  - Next state:
    - REQ with mem_gnt=1 -> FLUSH.
    - REQ with mem_gnt=0 -> REQ; the new address is driven next cycle.
    - WAIT with mem_rvalid=1 -> REQ; the byte is dropped.
    - WAIT with mem_rvalid=0 -> FLUSH.
    - DONE -> REQ.
    - FLUSH with mem_rvalid=1 -> REQ.
    - FLUSH with mem_rvalid=0 -> FLUSH, with the new pc kept.
  - In DONE, if_valid = !jump_flag, so a wrong-path instruction is never presented in the redirect cycle.
  - stall does not suppress a redirect.
- stall only affects DONE; byte fetching continues while stalled.
- Latency: with mem_gnt=1 on every request and mem_rvalid exactly one cycle after the grant, the instruction is in DONE 8 cycles after entering REQ with cnt=0.
- Reset mid-fetch: the in-flight byte is abandoned and state returns to REQ. The arbiter is also reset by rst, so no FLUSH is needed.

Test Plan:
- Reset, then memory {0x13,0x05,0x10,0x00} at 0..3 with gnt=1 and rvalid one cycle later -> requests to addresses 0,1,2,3. Cycle 8: if_valid=1, if_pc=0, if_inst=32'h0010_0513. Next request address is 4.
- Stall held for 3 cycles in DONE -> if_valid=1 with identical pc/inst for 3 cycles, no mem_req. Stall drops -> pc=4 and mem_addr=4 next cycle.
- mem_gnt=0 for 5 cycles in REQ -> mem_req=1 with mem_addr stable for all 5 cycles, then normal completion.
- jump_flag=1 with jump_addr=32'h0000_1003 in WAIT with no rvalid -> FLUSH. The returning byte is discarded, then requests go to 0x1000..0x1003 and if_pc=0x1000.
- jump_flag=1 in DONE with stall=1 -> if_valid=0 that cycle; next request address equals the jump target.
- pc=32'hFFFF_FFFC completes with stall=0 -> next mem_addr=0. Assert rst mid-WAIT -> all outputs 0 and refetch starts from RESET_PC.
